// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and port-count helpers.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_RDATA = 2'd2,
        ST_WDATA = 2'd3
    } arb_state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_priority_pick.sv
// Rotating priority pick: first set request at or after i_start (with wrap), returned one-hot.
module rr_priority_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = id_width(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic [N-1:0]     o_onehot,
    output logic             o_valid
);

    logic [N-1:0] w_rot;
    logic [N-1:0] w_hit;

    // Rotate so i_start lands at bit 0, pick the lowest set bit, rotate back.
    assign w_rot = N'({i_req, i_req} >> i_start);

    always_comb begin
        w_hit = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_hit    = '0;
                w_hit[k] = 1'b1;
            end
        end
    end

    assign o_onehot = N'(({w_hit, w_hit} << i_start) >> N);
    assign o_valid  = |i_req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Multi-port burst arbiter in front of a single memory port; one burst in flight at a time.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int LEN_W       = 8,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req_valid,
    output logic [NUM_PORTS-1:0]          req_ready,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*LEN_W-1:0]    req_len,
    input  logic [NUM_PORTS-1:0]          req_write,
    input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
    input  logic [NUM_PORTS-1:0]          wvalid,
    output logic [NUM_PORTS-1:0]          wready,
    output logic [DATA_W-1:0]             rdata,
    output logic [NUM_PORTS-1:0]          rvalid,
    output logic [NUM_PORTS-1:0]          rlast,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [ADDR_W-1:0]             m_addr,
    output logic [LEN_W-1:0]              m_len,
    output logic                          m_write,
    output logic [DATA_W-1:0]             m_wdata,
    output logic                          m_wvalid,
    input  logic                          m_wready,
    input  logic [DATA_W-1:0]             m_rdata,
    input  logic                          m_rvalid,
    input  logic                          m_rlast,
    output logic [id_width(NUM_PORTS)-1:0] grant_id,
    output logic                          busy
);

    localparam int ID_W = id_width(NUM_PORTS);

    arb_state_t          r_state;
    logic [ID_W-1:0]     r_grant;
    logic [ID_W-1:0]     r_last;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_cnt;
    logic                r_write;
    logic                r_m_valid;

    logic [ID_W-1:0]      w_start;
    logic [NUM_PORTS-1:0] w_pick;
    logic                 w_pick_vld;
    logic [ID_W-1:0]      w_win;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [LEN_W-1:0]     w_sel_len;
    logic                 w_sel_write;
    logic [DATA_W-1:0]    w_gnt_wdata;
    logic                 w_gnt_wvalid;
    logic                 w_last_beat;

    // Fixed priority is simply a rotating search that always starts at port 0.
    assign w_start = (ROUND_ROBIN == 0) ? '0 :
                     (r_last == ID_W'(NUM_PORTS - 1)) ? '0 : r_last + 1'b1;

    rr_priority_pick #(
        .N     (NUM_PORTS),
        .IDX_W (ID_W)
    ) u_pick (
        .i_req    (req_valid),
        .i_start  (w_start),
        .o_onehot (w_pick),
        .o_valid  (w_pick_vld)
    );

    always_comb begin
        w_win       = '0;
        w_sel_addr  = '0;
        w_sel_len   = '0;
        w_sel_write = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (w_pick[k]) begin
                w_win       = ID_W'(k);
                w_sel_addr  = req_addr[k*ADDR_W +: ADDR_W];
                w_sel_len   = req_len[k*LEN_W +: LEN_W];
                w_sel_write = req_write[k];
            end
        end
    end

    always_comb begin
        w_gnt_wdata  = '0;
        w_gnt_wvalid = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (r_grant == ID_W'(k)) begin
                w_gnt_wdata  = wdata[k*DATA_W +: DATA_W];
                w_gnt_wvalid = wvalid[k];
            end
        end
    end

    // The counter compares against len before incrementing, so len = all-ones never wraps.
    assign w_last_beat = (r_cnt == r_len);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_last    <= ID_W'(NUM_PORTS - 1);
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_write   <= 1'b0;
            r_m_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_addr    <= w_sel_addr;
                        r_len     <= w_sel_len;
                        r_write   <= w_sel_write;
                        r_grant   <= w_win;
                        r_cnt     <= '0;
                        r_m_valid <= 1'b1;
                        r_state   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= r_write ? ST_WDATA : ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (m_rvalid) begin
                        if (w_last_beat) begin
                            r_state <= ST_IDLE;
                            r_last  <= r_grant;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_WDATA: begin
                    if (w_gnt_wvalid && m_wready) begin
                        if (w_last_beat) begin
                            r_state <= ST_IDLE;
                            r_last  <= r_grant;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Memory-side rlast is only a consistency check; our own count ends the burst.
    always_ff @(posedge clk) begin
        if (rst && r_state == ST_RDATA && m_rvalid && m_rlast)
            assert (w_last_beat);
    end

    always_comb begin
        req_ready = '0;
        wready    = '0;
        rvalid    = '0;
        rlast     = '0;
        rdata     = '0;
        m_wdata   = '0;
        m_wvalid  = 1'b0;
        if (rst && r_state == ST_IDLE)
            req_ready = w_pick;
        if (r_state == ST_RDATA) begin
            rdata = m_rdata;
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (r_grant == ID_W'(k)) begin
                    rvalid[k] = m_rvalid;
                    rlast[k]  = m_rvalid && w_last_beat;
                end
            end
        end
        if (r_state == ST_WDATA) begin
            m_wdata  = w_gnt_wdata;
            m_wvalid = w_gnt_wvalid;
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (r_grant == ID_W'(k))
                    wready[k] = m_wready;
            end
        end
    end

    assign m_valid  = r_m_valid;
    assign m_addr   = r_addr;
    assign m_len    = r_len;
    assign m_write  = r_write;
    assign grant_id = r_grant;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of requester ports (2..8).
REQ-002 SHALL have parameter ADDR_W, default 64, byte address width.
REQ-003 SHALL have parameter DATA_W, default 64, data beat width.
REQ-004 SHALL have parameter LEN_W, default 8, burst length field width (beats = len+1).
REQ-005 SHALL have parameter ROUND_ROBIN, default 1, arbitration mode (1 = rotating priority, 0 = fixed, port 0 highest).
REQ-006 SHALL have the port clk, input, 1 bit, the single clock; all logic samples on its rising edge.
REQ-007 SHALL have the port rst, input, 1 bit, synchronous active-low reset.
REQ-008 SHALL have the ports req_valid/req_ready, in/out, NUM_PORTS bits, per-port request handshake.
REQ-009 SHALL have the port req_addr, input, NUM_PORTS x ADDR_W bits, burst start address.
REQ-010 SHALL have the ports req_len, input, NUM_PORTS x LEN_W bits, and req_write, input, NUM_PORTS bits, giving burst length and direction.
REQ-011 SHALL have the ports wdata, input, NUM_PORTS x DATA_W bits; wvalid, input, NUM_PORTS bits; and wready, output, NUM_PORTS bits, forming the per-port write beat channel.
REQ-012 SHALL have the ports rdata, output, DATA_W bits (shared), and rvalid/rlast, output, NUM_PORTS bits, forming the per-port read beat channel.
REQ-013 SHALL have the ports m_valid/m_ready, out/in, 1 bit; m_addr, out, ADDR_W bits; m_len, out, LEN_W bits; and m_write, out, 1 bit, forming the memory-side request.
REQ-014 SHALL have the ports m_wdata, out, DATA_W bits; m_wvalid, out, 1 bit; m_wready, in, 1 bit; m_rdata, in, DATA_W bits; m_rvalid, in, 1 bit; and m_rlast, in, 1 bit, forming the memory-side beat channels.
REQ-015 SHALL have the ports grant_id, out, clog2(NUM_PORTS) bits, and busy, out, 1 bit, as status.

Function
REQ-016 SHALL implement FSM states IDLE, ADDR, RDATA and WDATA.
REQ-017 SHALL, in IDLE with any req_valid set, select a winner in that cycle, latch its addr/len/write and the winner id, and enter ADDR on the next edge.
REQ-018 SHALL, when ROUND_ROBIN=1, search from port (last_grant+1) mod NUM_PORTS upward with wrap-around; when ROUND_ROBIN=0, select the lowest-index requester.
REQ-019 SHALL assert req_ready[winner] for exactly the IDLE selection cycle, and SHALL hold req_ready low for all other ports and states.
REQ-020 SHALL, in ADDR, drive m_valid=1 with the latched fields, holding them stable until m_ready; on m_ready it SHALL enter RDATA or WDATA per the latched write bit.
REQ-021 SHALL, in RDATA, drive rdata=m_rdata and rvalid[grant]=m_rvalid combinationally (zero added latency); rvalid SHALL be 0 for other ports.
REQ-022 SHALL, in RDATA, assert rlast[grant] on the beat where the beat counter equals len, and return to IDLE after that beat, ignoring m_rlast except as an error check.
REQ-023 SHALL, in WDATA, route wdata/wvalid of grant to m_wdata/m_wvalid and m_wready to wready[grant], count accepted beats, and return to IDLE after beat len+1.
REQ-024 SHALL use a beat counter LEN_W bits wide, reset to 0 on each grant; len = 2^LEN_W-1 SHALL complete without overflow.
REQ-025 SHALL update last_grant only on burst completion.
REQ-026 SHALL, when a requester drops req_valid before selection, not grant that port; a port re-requesting on its completion cycle SHALL wait one IDLE cycle (back-to-back bursts carry 1 idle cycle).
REQ-027 SHALL assert busy in every state except IDLE; grant_id SHALL hold the last winner.

Reset
REQ-028 SHALL, while rst=0 at a clock edge, enter IDLE, set last_grant=NUM_PORTS-1 (so port 0 wins first), clear the beat counter, and drive all outputs to 0.
REQ-029 SHALL, on reset mid-burst, abandon the burst immediately with no completion pulse.

Structure
REQ-030 SHALL place the FSM state enum in the shared package as arb_state_t.
REQ-031 SHALL implement the rotating priority search in the sub-module rr_priority_pick (request vector, start index -> one-hot, valid).

Verification
REQ-032 SHALL cover: ports 0 and 1 request reads with len=3 in the same cycle, RR=1 -> port 0 gets 4 rvalid beats with rlast on the 4th, then port 1 is served.
REQ-033 SHALL cover: 3 ports request continuously, RR=1 -> grant order 0,1,2,0,1,2.
REQ-034 SHALL cover: RR=0, both ports requesting continuously -> port 0 always wins and port 1 starves.
REQ-035 SHALL cover: a port-1 write with len=1 and m_wready toggling 0/1 -> exactly 2 m_wvalid&m_wready beats, then IDLE.
REQ-036 SHALL cover: rst=0 asserted during beat 2 of an 8-beat read -> next cycle busy=0 and all outputs 0, and the next grant goes to port 0.
REQ-037 SHALL cover: len=255 read -> 256 beats, counter does not wrap early, rlast on beat 256.
